char_store_seq: RTL and testbench

//  Write-side address sequencer for character/tensor buffers: counterpart of the read-side

---
 rtl/char_store_seq_pkg.sv | 10 +
 rtl/char_store_seq_if.sv | 33 +++
 rtl/char_store_seq_addr_step.sv | 19 +
 rtl/char_store_seq.sv | 97 +++++++++
 tb/tb_char_store_seq.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_store_seq_pkg.sv
// Shared types and defaults for the character/tensor buffer address sequencers.
package char_store_seq_pkg;
  localparam int CSS_ADDR_WIDTH = 4;
  localparam int CSS_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } char_seq_state_t;
endpackage

// File: rtl/char_store_seq_if.sv
// Stream-in / buffer-write bundle for the write-side sequencer.
interface char_store_seq_if
  import char_store_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = CSS_ADDR_WIDTH,
  parameter int DATA_WIDTH = CSS_DATA_WIDTH
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output start, abort, start_addr, end_addr, stride, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );

  modport slave (
    input  start, abort, start_addr, end_addr, stride, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );
endinterface

// File: rtl/char_store_seq_addr_step.sv
// Strided address step with overflow-safe last-address detection; shared with read-side incrementers.
module char_addr_step
  import char_store_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = CSS_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] curr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  last
);
  // One extra bit so a step past the top of the address space is seen as "beyond end".
  logic [ADDR_WIDTH:0] sum;

  assign sum       = {1'b0, curr} + {1'b0, stride};
  assign next_addr = sum[ADDR_WIDTH-1:0];
  assign last      = (curr == end_addr) | (sum > {1'b0, end_addr});
endmodule

// File: rtl/char_store_seq.sv
// Write-side address sequencer: stores a valid/ready stream at start, start+stride, ... end.
//   state | meaning
//   IDLE  | waiting for start; cfg checked, err updated
//   RUN   | accepting beats, one registered write per accepted beat
module char_store_seq
  import char_store_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = CSS_ADDR_WIDTH,
  parameter int DATA_WIDTH = CSS_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  char_store_seq_if.slave bus
);
  char_seq_state_t       state;
  logic [ADDR_WIDTH-1:0] curr;
  logic [ADDR_WIDTH-1:0] end_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last;
  logic                  accept;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  done_r;
  logic                  err_r;
  logic [ADDR_WIDTH:0]   word_count_r;

  char_addr_step #(.ADDR_WIDTH(ADDR_WIDTH)) u_step (
    .curr      (curr),
    .stride    (stride_r),
    .end_addr  (end_r),
    .next_addr (next_addr),
    .last      (last)
  );

  assign bus.in_ready   = (state == RUN) & ~bus.abort;
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.busy       = (state == RUN);
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.word_count = word_count_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      curr         <= '0;
      end_r        <= '0;
      stride_r     <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      word_count_r <= '0;
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            word_count_r <= '0;
            if (bus.start_addr > bus.end_addr) begin
              err_r <= 1'b1;
            end else begin
              err_r    <= 1'b0;
              curr     <= bus.start_addr;
              end_r    <= bus.end_addr;
              stride_r <= (bus.stride == '0) ? ADDR_WIDTH'(1) : bus.stride;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (accept) begin
            mem_we_r     <= 1'b1;
            mem_addr_r   <= curr;
            mem_wdata_r  <= bus.in_data;
            word_count_r <= word_count_r + (ADDR_WIDTH+1)'(1);
            if (last) begin
              done_r <= 1'b1;
              state  <= IDLE;
            end else begin
              curr <= next_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_char_store_seq.sv
// Bench for char_store_seq: table of directed sequences, random sequences, and hand-written corner cases.
module tb_char_store_seq;
  import char_store_seq_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    int s;
    int e;
    int st;
    int mode;            // 0 continuous, 1 every other cycle, 2 random valid
    int abort_after;     // accepts before abort pulse, -1 none
    int restart_at;      // accepts before an ignored start pulse in RUN, -1 none
    int abort_at_start;  // abort asserted together with start
    int exp_nwr;         // -1: take from reference model
    int exp_last;
    int exp_done;
    int exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  char_store_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  char_store_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_addr[$];
  int wq_addr[$];
  int wq_data[$];
  int wq_cnt[$];
  int sent_q[$];
  int done_cnt;
  int done_addr;
  int done_no_we;
  vec_t vecs[12];

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Reference: the address list a sequence must cover, from plain arithmetic.
  function automatic void build_model(int s, int e, int st);
    int a;
    int inc;
    exp_addr.delete();
    if (s > e) return;
    inc = (st == 0) ? 1 : st;
    a = s;
    while (a <= e) begin
      exp_addr.push_back(a);
      a += inc;
    end
  endfunction

  task automatic clear_cap();
    wq_addr.delete();
    wq_data.delete();
    wq_cnt.delete();
    sent_q.delete();
    done_cnt   = 0;
    done_addr  = -1;
    done_no_we = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mem_we) begin
      wq_addr.push_back(int'(bus.mem_addr));
      wq_data.push_back(int'(bus.mem_wdata));
      wq_cnt.push_back(int'(bus.word_count));
    end
    if (bus.done) begin
      done_cnt++;
      done_addr = int'(bus.mem_addr);
      if (!bus.mem_we) done_no_we++;
    end
  endtask

  task automatic drive_idle();
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  exp_nwr, exp_done, exp_err, exp_last;
    int  n_acc, cyc, post, nmin;
    bit  aborted, restarted, ab_now, vb;
    clear_cap();
    build_model(v.s, v.e, v.st);
    exp_err  = (v.exp_err >= 0) ? v.exp_err : int'(v.s > v.e);
    exp_nwr  = (v.exp_nwr >= 0) ? v.exp_nwr
             : ((v.abort_after >= 0) ? v.abort_after : exp_addr.size());
    exp_done = (v.exp_done >= 0) ? v.exp_done
             : int'(v.abort_after < 0 && exp_addr.size() > 0);
    exp_last = (v.exp_last >= 0) ? v.exp_last
             : ((exp_nwr > 0 && exp_nwr <= exp_addr.size()) ? exp_addr[exp_nwr-1] : -1);

    bus.start      = 1'b1;
    bus.abort      = v.abort_at_start[0];
    bus.start_addr = AW'(v.s);
    bus.end_addr   = AW'(v.e);
    bus.stride     = AW'(v.st);
    bus.in_valid   = 1'b0;
    step();
    drive_idle();
    chk({tag, " err"}, int'(bus.err), exp_err);
    chk({tag, " busy_after_start"}, int'(bus.busy), 1 - exp_err);

    n_acc = 0; cyc = 0; post = 0;
    aborted = 1'b0; restarted = 1'b0;
    while (post < 4 && cyc < 200) begin
      ab_now = 1'b0;
      case (v.mode)
        0:       vb = 1'b1;
        1:       vb = (cyc % 2 == 0);
        default: vb = ($urandom_range(0, 1) == 1);
      endcase
      bus.in_valid = vb;
      bus.in_data  = DW'($urandom_range(0, 255));
      bus.abort    = 1'b0;
      bus.start    = 1'b0;
      if (v.abort_after >= 0 && !aborted && n_acc == v.abort_after) begin
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        aborted      = 1'b1;
        ab_now       = 1'b1;
      end
      if (v.restart_at >= 0 && !restarted && n_acc == v.restart_at) begin
        bus.start      = 1'b1;
        bus.start_addr = AW'(10);
        bus.end_addr   = AW'(12);
        restarted      = 1'b1;
      end
      #1;
      if (ab_now) chk({tag, " ready_during_abort"}, int'(bus.in_ready), 0);
      if (bus.in_valid && bus.in_ready) begin
        sent_q.push_back(int'(bus.in_data));
        n_acc++;
      end
      step();
      cyc++;
      if (aborted || n_acc >= exp_addr.size()) post++;
    end
    drive_idle();

    chk({tag, " no_timeout"}, int'(cyc < 200), 1);
    chk({tag, " nwrites"}, wq_addr.size(), exp_nwr);
    nmin = (wq_addr.size() < exp_nwr) ? wq_addr.size() : exp_nwr;
    for (int i = 0; i < nmin; i++) begin
      if (i < exp_addr.size()) chk($sformatf("%s addr[%0d]", tag, i), wq_addr[i], exp_addr[i]);
      if (i < sent_q.size())   chk($sformatf("%s data[%0d]", tag, i), wq_data[i], sent_q[i]);
      chk($sformatf("%s count[%0d]", tag, i), wq_cnt[i], i + 1);
    end
    if (wq_addr.size() > 0 && exp_nwr > 0) chk({tag, " last_addr"}, wq_addr[$], exp_last);
    chk({tag, " done_pulses"}, done_cnt, exp_done);
    if (exp_done != 0) chk({tag, " done_addr"}, done_addr, exp_last);
    chk({tag, " done_without_we"}, done_no_we, 0);
    chk({tag, " busy_end"}, int'(bus.busy), 0);
    chk({tag, " ready_end"}, int'(bus.in_ready), 0);
    chk({tag, " word_count_end"}, int'(bus.word_count), exp_nwr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   n_acc;
    drive_idle();
    bus.start_addr = '0;
    bus.end_addr   = '0;
    bus.stride     = '0;

    //              s  e  st md ab  rs as nwr last dn er
    vecs[0]  = '{ 2,  9, 1, 0, -1,  3, 0,  8,  9, 1, 0};
    vecs[1]  = '{ 1, 10, 3, 0, -1, -1, 0,  4, 10, 1, 0};
    vecs[2]  = '{12, 15, 3, 0, -1, -1, 0,  2, 15, 1, 0};
    vecs[3]  = '{14, 15, 4, 0, -1, -1, 0,  1, 14, 1, 0};
    vecs[4]  = '{ 9,  3, 1, 0, -1, -1, 0,  0, -1, 0, 1};
    vecs[5]  = '{ 0,  0, 5, 0, -1, -1, 0,  1,  0, 1, 0};
    vecs[6]  = '{ 0, 15, 0, 1, -1, -1, 0, 16, 15, 1, 0};
    vecs[7]  = '{ 0,  7, 1, 0,  3, -1, 0,  3,  2, 0, 0};
    vecs[8]  = '{ 3, 15, 4, 2, -1, -1, 0,  4, 15, 1, 0};
    vecs[9]  = '{15, 15, 1, 0, -1, -1, 1,  1, 15, 1, 0};
    vecs[10] = '{ 0, 15,15, 1, -1, -1, 0,  2, 15, 1, 0};
    vecs[11] = '{ 5, 14, 7, 2, -1, -1, 0,  2, 12, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_we", int'(bus.mem_we), 0);
    chk("rst mem_addr", int'(bus.mem_addr), 0);
    chk("rst mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst word_count", int'(bus.word_count), 0);
    chk("rst in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;

    // abort while idle must not start anything
    clear_cap();
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    step();
    drive_idle();
    chk("idle_abort busy", int'(bus.busy), 0);
    chk("idle_abort writes", wq_addr.size(), 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a run, with a write in flight
    clear_cap();
    bus.start = 1'b1; bus.start_addr = AW'(0); bus.end_addr = AW'(7); bus.stride = AW'(1);
    step();
    drive_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(8'hA5);
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.in_ready) n_acc++;
      step();
    end
    chk("midrst accepted", n_acc, 3);
    chk("midrst we_before", int'(bus.mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst mem_we", int'(bus.mem_we), 0);
    chk("midrst mem_addr", int'(bus.mem_addr), 0);
    chk("midrst mem_wdata", int'(bus.mem_wdata), 0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst word_count", int'(bus.word_count), 0);
    chk("midrst in_ready", int'(bus.in_ready), 0);
    #1;
    rst_n = 1'b1;
    clear_cap();
    step();
    step();
    drive_idle();
    chk("postrst writes", wq_addr.size(), 0);
    chk("postrst busy", int'(bus.busy), 0);

    for (int k = 0; k < 25; k++) begin
      rv.s  = $urandom_range(0, 15);
      rv.e  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0 && rv.s > rv.e) begin
        int t;
        t = rv.s; rv.s = rv.e; rv.e = t;
      end
      rv.st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      rv.mode = $urandom_range(0, 2);
      build_model(rv.s, rv.e, rv.st);
      rv.abort_after = (exp_addr.size() > 1 && $urandom_range(0, 3) == 0)
                     ? $urandom_range(0, exp_addr.size() - 1) : -1;
      rv.restart_at     = -1;
      rv.abort_at_start = $urandom_range(0, 1);
      rv.exp_nwr  = -1;
      rv.exp_last = -1;
      rv.exp_done = -1;
      rv.exp_err  = -1;
      run_vec(rv, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
